mem_port_arbiter: RTL and testbench

// - Shares one single-ported backing memory between the IF-stage fetch requester (I) and MEM-stage load/store requester (D).
// - One outstanding transaction at a time; requesters stall by holding REQ until GNT and waiting for RVALID.
// - Sits between if_stage/mem_stage and the unified memory; replaces separate IMEM/DMEM arrays in unified-memory builds.

---
 rtl/mem_port_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// Bundle of the fetch (I), data (D) and memory (M) handshakes around mem_port_arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              I_REQ;
  logic [ADDR_W-1:0] I_ADDR;
  logic              I_GNT;
  logic              I_RVALID;
  logic [DATA_W-1:0] I_RDATA;

  logic              D_REQ;
  logic              D_WE;
  logic [BE_W-1:0]   D_BE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [DATA_W-1:0] D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic [DATA_W-1:0] D_RDATA;

  logic              M_REQ;
  logic              M_WE;
  logic [BE_W-1:0]   M_BE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_WDATA;
  logic              M_READY;
  logic              M_RVALID;
  logic [DATA_W-1:0] M_RDATA;

  logic              BUS_ERR;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_READY, M_RVALID, M_RDATA,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
           M_REQ, M_WE, M_BE, M_ADDR, M_WDATA, BUS_ERR
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_READY, M_RVALID, M_RDATA,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
           M_REQ, M_WE, M_BE, M_ADDR, M_WDATA, BUS_ERR
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D), one transaction at a time.
// Define MEMARB_RR_EN for round-robin arbitration; default is fixed priority D over I.
//
// state | meaning
// IDLE  | no transaction; arbitrate and grant combinationally
// ISSUE | M_REQ held with registered command until M_READY
// WAIT  | waiting for M_RVALID (or timeout) to complete the owner's request
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic      CLK,
  input logic      RST,
  mem_port_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state;
  logic             owner_d;
  logic [CNT_W-1:0] cnt;
  logic             win_d;
  logic             win_i;
  logic             grant;
  logic             done;
  logic             abort;

`ifdef MEMARB_RR_EN
  // last_d remembers whether D took the previous grant; reset behaves as if I did
  logic last_d;

  always_comb win_d = bus.D_REQ && (!bus.I_REQ || !last_d);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) last_d <= 1'b0;
    else if (grant) last_d <= win_d;
  end
`else
  always_comb win_d = bus.D_REQ;
`endif

  assign win_i = bus.I_REQ && !win_d;
  assign grant = (state == S_IDLE) && (bus.I_REQ || bus.D_REQ);

  assign bus.I_GNT = (state == S_IDLE) && win_i;
  assign bus.D_GNT = (state == S_IDLE) && win_d;

  // real memory data beats a timeout landing in the same cycle
  assign done  = (state == S_WAIT) && bus.M_RVALID;
  assign abort = (TIMEOUT != 0) && (state != S_IDLE) && (cnt == CNT_LAST) && !done;

  assign bus.I_RVALID = (done || abort) && !owner_d;
  assign bus.D_RVALID = (done || abort) && owner_d;
  assign bus.I_RDATA  = (done && !owner_d) ? bus.M_RDATA : '0;
  assign bus.D_RDATA  = (done && owner_d && !bus.M_WE) ? bus.M_RDATA : '0;
  assign bus.BUS_ERR  = abort;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      owner_d     <= 1'b0;
      cnt         <= '0;
      bus.M_REQ   <= 1'b0;
      bus.M_WE    <= 1'b0;
      bus.M_BE    <= '0;
      bus.M_ADDR  <= '0;
      bus.M_WDATA <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            state     <= S_ISSUE;
            owner_d   <= win_d;
            cnt       <= '0;
            bus.M_REQ <= 1'b1;
            if (win_d) begin
              bus.M_WE    <= bus.D_WE;
              bus.M_BE    <= bus.D_WE ? bus.D_BE : {BE_W{1'b1}};
              bus.M_ADDR  <= bus.D_ADDR;
              bus.M_WDATA <= bus.D_WDATA;
            end else begin
              bus.M_WE    <= 1'b0;
              bus.M_BE    <= {BE_W{1'b1}};
              bus.M_ADDR  <= bus.I_ADDR;
              bus.M_WDATA <= '0;
            end
          end
        end
        S_ISSUE: begin
          cnt <= cnt + 1'b1;
          if (abort) begin
            state     <= S_IDLE;
            bus.M_REQ <= 1'b0;
          end else if (bus.M_READY) begin
            state     <= S_WAIT;
            bus.M_REQ <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (done || abort) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=8); completions are checked against a queue of
// expected responses filled as each request is driven.
module tb_mem_port_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  mem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    bit          d;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input bit d, input logic [31:0] data, input bit err);
    exp_t e;
    e.d = d; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  // zero-wait memory: ready in the cycle after grant, data the cycle after that
  task automatic serve(input logic [31:0] data);
    step(); bus.M_READY = 1'b1; bus.M_RVALID = 1'b0; settle();
    step(); bus.M_READY = 1'b0; bus.M_RVALID = 1'b1; bus.M_RDATA = data; settle();
    step(); bus.M_RVALID = 1'b0; bus.M_RDATA = '0;
  endtask

  always @(negedge CLK) begin
    if (bus.I_RVALID || bus.D_RVALID) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 32'({bus.I_RVALID, bus.D_RVALID}), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rvalid_port", 32'({bus.I_RVALID, bus.D_RVALID}), e.d ? 32'd1 : 32'd2);
        check("rdata", e.d ? bus.D_RDATA : bus.I_RDATA, e.data);
        check("bus_err", 32'(bus.BUS_ERR), 32'(e.err));
      end
    end else if (bus.BUS_ERR) begin
      check("bus_err_stray", 32'(bus.BUS_ERR), 0);
    end
  end

  initial begin
    bus.I_REQ = 0; bus.I_ADDR = '0;
    bus.D_REQ = 0; bus.D_WE = 0; bus.D_BE = '0; bus.D_ADDR = '0; bus.D_WDATA = '0;
    bus.M_READY = 0; bus.M_RVALID = 0; bus.M_RDATA = '0;

    // reset state
    step(); settle();
    check("rst_m_req",   32'(bus.M_REQ), 0);
    check("rst_m_we",    32'(bus.M_WE), 0);
    check("rst_m_be",    32'(bus.M_BE), 0);
    check("rst_m_addr",  bus.M_ADDR, 0);
    check("rst_m_wdata", bus.M_WDATA, 0);
    check("rst_gnt",     32'({bus.I_GNT, bus.D_GNT}), 0);
    check("rst_rvalid",  32'({bus.I_RVALID, bus.D_RVALID}), 0);
    check("rst_bus_err", 32'(bus.BUS_ERR), 0);

    // M_RVALID while idle must be ignored
    step(); RST = 0; bus.M_RVALID = 1; bus.M_RDATA = 32'hFFFF; settle();
    check("idle_m_req", 32'(bus.M_REQ), 0);
    step(); bus.M_RVALID = 0; bus.M_RDATA = '0;

    // lone fetch, minimum latency
    bus.I_REQ = 1; bus.I_ADDR = 32'h40; push(0, 32'h13, 0); settle();
    check("t1_i_gnt", 32'(bus.I_GNT), 1);
    check("t1_d_gnt", 32'(bus.D_GNT), 0);
    step(); bus.M_READY = 1; settle();
    check("t1_m_req",  32'(bus.M_REQ), 1);
    check("t1_m_addr", bus.M_ADDR, 32'h40);
    check("t1_m_be",   32'(bus.M_BE), 32'hF);
    check("t1_m_we",   32'(bus.M_WE), 0);
    step(); bus.M_READY = 0; bus.M_RVALID = 1; bus.M_RDATA = 32'h13; settle();
    check("t1_m_req_drop", 32'(bus.M_REQ), 0);
    step(); bus.M_RVALID = 0; bus.M_RDATA = '0; bus.I_REQ = 0;

    // contention with a store: D first, I only after D completes
    bus.I_REQ = 1; bus.I_ADDR = 32'h80;
    bus.D_REQ = 1; bus.D_WE = 1; bus.D_ADDR = 32'h100000; bus.D_BE = 4'h3; bus.D_WDATA = 32'hBEEF;
    push(1, 32'h0, 0); settle();
    check("t2_d_gnt", 32'(bus.D_GNT), 1);
    check("t2_i_gnt", 32'(bus.I_GNT), 0);
    step(); bus.D_REQ = 0; bus.M_READY = 1; settle();
    check("t2_m_we",    32'(bus.M_WE), 1);
    check("t2_m_be",    32'(bus.M_BE), 32'h3);
    check("t2_m_addr",  bus.M_ADDR, 32'h100000);
    check("t2_m_wdata", bus.M_WDATA, 32'hBEEF);
    check("t2_i_gnt_issue", 32'(bus.I_GNT), 0);
    step(); bus.M_READY = 0; bus.M_RVALID = 1; bus.M_RDATA = 32'hDEAD; settle();
    check("t2_i_gnt_wait", 32'(bus.I_GNT), 0);
    step(); bus.M_RVALID = 0; bus.M_RDATA = '0; bus.D_WE = 0;
    push(0, 32'h1234, 0); settle();
    check("t2_i_gnt_after", 32'(bus.I_GNT), 1);
    serve(32'h1234);
    bus.I_REQ = 0;

    // repeated contention, both requests held throughout
    bus.I_REQ = 1; bus.I_ADDR = 32'h600; bus.D_REQ = 1; bus.D_ADDR = 32'h500;
    for (int k = 0; k < 4; k++) begin
      bit exp_d;
`ifdef MEMARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      push(exp_d, 32'h1000 + k, 0); settle();
      check($sformatf("t3_d_gnt_%0d", k), 32'(bus.D_GNT), 32'(exp_d));
      check($sformatf("t3_i_gnt_%0d", k), 32'(bus.I_GNT), 32'(!exp_d));
      serve(32'h1000 + k);
    end
    bus.I_REQ = 0; bus.D_REQ = 0;

    // memory stalls M_READY for 5 cycles
    bus.I_REQ = 1; bus.I_ADDR = 32'h200; push(0, 32'h55, 0); settle();
    check("t4_i_gnt", 32'(bus.I_GNT), 1);
    for (int k = 1; k <= 5; k++) begin
      step(); bus.I_REQ = 0; settle();
      check($sformatf("t4_m_req_%0d", k), 32'(bus.M_REQ), 1);
      check($sformatf("t4_m_addr_%0d", k), bus.M_ADDR, 32'h200);
    end
    step(); bus.M_READY = 1; settle();
    check("t4_m_req_ready", 32'(bus.M_REQ), 1);
    step(); bus.M_READY = 0; bus.M_RVALID = 1; bus.M_RDATA = 32'h55; settle();
    step(); bus.M_RVALID = 0; bus.M_RDATA = '0;

    // timeout: memory never answers
    bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 32'h300; push(1, 32'h0, 1); settle();
    check("t5_d_gnt", 32'(bus.D_GNT), 1);
    for (int k = 1; k <= 7; k++) begin
      step(); bus.D_REQ = 0; settle();
      check($sformatf("t5_no_err_%0d", k), 32'(bus.BUS_ERR), 0);
      check($sformatf("t5_m_req_%0d", k), 32'(bus.M_REQ), 1);
    end
    step(); settle();
    step(); settle();
    check("t5_m_req_after", 32'(bus.M_REQ), 0);
    step(); bus.I_REQ = 1; bus.I_ADDR = 32'h44; push(0, 32'h77, 0); settle();
    check("t5_next_gnt", 32'(bus.I_GNT), 1);
    serve(32'h77);
    bus.I_REQ = 0;

    // data arrives in the very cycle the timeout would fire
    bus.I_REQ = 1; bus.I_ADDR = 32'h48; push(0, 32'hAB, 0); settle();
    step(); bus.I_REQ = 0; bus.M_READY = 1; settle();
    step(); bus.M_READY = 0; settle();
    for (int k = 3; k <= 7; k++) begin
      step(); settle();
    end
    step(); bus.M_RVALID = 1; bus.M_RDATA = 32'hAB; settle();
    step(); bus.M_RVALID = 0; bus.M_RDATA = '0;

    // reset during WAIT discards the transaction
    bus.I_REQ = 1; bus.I_ADDR = 32'h60; settle();
    check("t6_i_gnt", 32'(bus.I_GNT), 1);
    step(); bus.I_REQ = 0; bus.M_READY = 1; settle();
    step(); bus.M_READY = 0; RST = 1; settle();
    check("t6_rst_m_req",  32'(bus.M_REQ), 0);
    check("t6_rst_m_addr", bus.M_ADDR, 0);
    step(); RST = 0; bus.M_RVALID = 1; bus.M_RDATA = 32'hBAD;
    bus.I_REQ = 1; bus.I_ADDR = 32'h64; push(0, 32'h99, 0); settle();
    check("t6_i_gnt_after", 32'(bus.I_GNT), 1);
    check("t6_m_req_idle",  32'(bus.M_REQ), 0);
    serve(32'h99);
    bus.I_REQ = 0;

    step(); settle();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
